// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/busy/done handshake and operand/result bus between ALU control and shift unit
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] A;
  logic [31:0] result;
  logic        busy;
  logic        done;
  modport master (output start, op, shamt, A, input result, busy, done);
  modport slave (input start, op, shamt, A, output result, busy, done);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: five-step iterative 32-bit SLL/SRL/SRA/ROR using one barrel level per cycle
module shift_sequencer (
  input logic clk,
  input logic rst_n,
  shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [2:0] level, level_n;
  logic [1:0] op_r, op_n;
  logic [4:0] sh_r, sh_n;
  logic [31:0] res, res_n, sra, staged;
  logic [5:0] d;
  logic [63:0] rot;
  always_comb begin
    d = 6'd1 << level;
    rot = {res, res} >> d;
    sra = $signed(res) >>> d;
    staged = op_r == 2'd0 ? res << d : op_r == 2'd1 ? res >> d : op_r == 2'd2 ? sra : rot[31:0];
  end
  always_comb begin
    state_n = state;
    level_n = level;
    op_n = op_r;
    sh_n = sh_r;
    res_n = res;
    if (state == SHIFT) begin
      res_n = sh_r[level] ? staged : res;
      level_n = level == 3'd4 ? level : level + 3'd1;
      state_n = level == 3'd4 ? DONE : SHIFT;
    end else if (bus.start) begin
      res_n = bus.A;
      op_n = bus.op;
      sh_n = bus.shamt;
      level_n = 3'd0;
      state_n = SHIFT;
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= 3'd0;
      op_r <= 2'd0;
      sh_r <= 5'd0;
      res <= 32'd0;
    end else begin
      state <= state_n;
      level <= level_n;
      op_r <= op_n;
      sh_r <= sh_n;
      res <= res_n;
    end
  end
  assign bus.result = res;
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
endmodule
